// File: rtl/instruction_queue.sv
// Instruction queue between fetch and dispatch.
// A circular buffer of DEPTH {inst, pc} entries. The head and tail pointers
// each carry one extra wrap bit, so a full queue and an empty queue can be
// told apart without keeping a separate occupancy register.
// Optional build macro: IQUEUE_PERF_CNT_EN enables the full-stall and
// empty-cycle performance counters. Without it both counter outputs are 0
// and no counter flops exist.
module instruction_queue #(
  parameter int DEPTH    = 16,
  parameter int CNT_BITS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enqueue,
  input  logic [31:0]                inst_in,
  input  logic [31:0]                pc_in,
  input  logic                       dequeue,
  input  logic                       flush,
  output logic [31:0]                inst_out,
  output logic [31:0]                pc_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_BITS-1:0]        full_stall_cnt,
  output logic [CNT_BITS-1:0]        empty_cycle_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             enq_acc;
  logic             deq_acc;

  // Occupancy flags and head read; the wrap bit separates full from empty.
  always_comb begin
    empty    = (head == tail);
    full     = (head[IDX_W] != tail[IDX_W]) &&
               (head[IDX_W-1:0] == tail[IDX_W-1:0]);
    count    = tail - head;
    enq_acc  = enqueue && !full && !flush;
    deq_acc  = dequeue && !empty && !flush;
    inst_out = 32'h0;
    pc_out   = 32'h0;
    if (!empty) begin
      inst_out = mem_inst[head[IDX_W-1:0]];
      pc_out   = mem_pc[head[IDX_W-1:0]];
    end
  end

  // Pointer update; reset and flush both return the queue to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_acc) tail <= tail + PTR_ONE;
      if (deq_acc) head <= head + PTR_ONE;
    end
  end

  // Entry storage is never cleared; validity comes only from the pointers.
  always_ff @(posedge clk) begin
    if (enq_acc && !rst) begin
      mem_inst[tail[IDX_W-1:0]] <= inst_in;
      mem_pc[tail[IDX_W-1:0]]   <= pc_in;
    end
  end

`ifdef IQUEUE_PERF_CNT_EN
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic [CNT_BITS-1:0] stall_q;
  logic [CNT_BITS-1:0] empty_q;

  // Saturating performance counters; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      empty_q <= '0;
    end else begin
      if (enqueue && full && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
      if (empty && (empty_q != '1))           empty_q <= empty_q + CNT_ONE;
    end
  end

  assign full_stall_cnt  = stall_q;
  assign empty_cycle_cnt = empty_q;
`else
  assign full_stall_cnt  = '0;
  assign empty_cycle_cnt = '0;
`endif

endmodule
